cl_systolic_sched: RTL and testbench

//  Run-time scheduler for the A/OUT BRAM (port B read, port A write) and the systolic array.

---
 rtl/cl_systolic_sched.sv | 151 +++++++++++++++
 tb/tb_cl_systolic_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cl_systolic_sched.sv
// cl_systolic_sched: A-row fetch / result writeback scheduler for the systolic array BRAM.
// Optional SCHED_PERF_EN builds the job cycle counter on perf_cycles.
module cl_systolic_sched #(
  parameter int DEPTH     = 128,
  parameter int AW        = 7,
  parameter int DRAIN_MAX = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] out_base,
  input  logic [AW:0]   num_rows,
  input  logic          res_valid,
  output logic          work,
  output logic          out_in,
  output logic          in_out,
  output logic [31:0]   memory_address_A,
  output logic [31:0]   memory_address_OUT,
  output logic          arr_in_valid,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   perf_cycles
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);
  localparam logic [AW:0]   MAX_ROWS   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C      = 1;
  localparam logic [AW-1:0] ONE_A      = 1;
  localparam logic [DW-1:0] ONE_D      = 1;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] out_base_q;
  logic [AW:0]   num_q;
  logic [AW:0]   rd_cnt;
  logic [AW:0]   wr_cnt;
  logic [AW:0]   wr_cnt_nx;
  logic [DW-1:0] drain_cnt;
  logic          err_q;
  logic          aiv_q;

  logic active;
  logic go;
  logic busy_start;
  logic wr_en;
  logic wr_over;
  logic last_rd;
  logic fill_done;
  logic timeout;

  assign active     = (state == S_FETCH) || (state == S_DRAIN);
  assign go         = start && !abort && (state == S_IDLE);
  assign busy_start = start && !abort && (state != S_IDLE);
  assign wr_en      = active && res_valid && !abort && (wr_cnt != num_q);
  assign wr_over    = active && res_valid && !abort && (wr_cnt == num_q);
  assign wr_cnt_nx  = wr_en ? wr_cnt + ONE_C : wr_cnt;
  assign last_rd    = (rd_cnt + ONE_C) == num_q;
  assign fill_done  = wr_cnt_nx == num_q;
  // a result arriving this cycle restarts the idle window
  assign timeout    = (state == S_DRAIN) && !abort && !res_valid &&
                      !fill_done && (drain_cnt == DRAIN_LAST);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (go) state_nx = (num_rows == '0) ? S_FIN : S_FETCH;
      end
      S_FETCH: begin
        if (last_rd) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (fill_done || timeout) state_nx = S_FIN;
      end
      S_FIN: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_addr    <= '0;
      out_base_q <= '0;
      num_q      <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      drain_cnt  <= '0;
      err_q      <= 1'b0;
      aiv_q      <= 1'b0;
    end else begin
      state <= state_nx;
      aiv_q <= out_in;
      unique case (1'b1)
        go: begin
          rd_addr    <= a_base;
          out_base_q <= out_base;
          num_q      <= (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
          rd_cnt     <= '0;
          wr_cnt     <= '0;
        end
        (state == S_FETCH): begin
          rd_addr <= rd_addr + ONE_A;
          rd_cnt  <= rd_cnt + ONE_C;
          wr_cnt  <= wr_cnt_nx;
        end
        default: wr_cnt <= wr_cnt_nx;
      endcase
      if ((state != S_DRAIN) || res_valid) drain_cnt <= '0;
      else drain_cnt <= drain_cnt + ONE_D;
      if (go) err_q <= 1'b0;
      else if (busy_start || wr_over || timeout) err_q <= 1'b1;
    end
  end

  assign work               = active;
  assign out_in             = state == S_FETCH;
  assign in_out             = wr_en;
  assign memory_address_A   = {{(32-AW){1'b0}}, rd_addr};
  assign memory_address_OUT = {{(32-AW){1'b0}}, out_base_q + wr_cnt[AW-1:0]};
  assign arr_in_valid       = aiv_q;
  assign busy               = state != S_IDLE;
  assign done               = state == S_FIN;
  assign err                = err_q;

`ifdef SCHED_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else if (go) perf_q <= '0;
    else if (state != S_IDLE) perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_cl_systolic_sched.sv
// tb_cl_systolic_sched: directed and random jobs checked against a job-level model.
// Expected addresses, done cycle, err and perf come from the scheduling rules directly.
module tb_cl_systolic_sched;

  localparam int DRAIN_MAX = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  a_base = '0;
  logic [6:0]  out_base = '0;
  logic [7:0]  num_rows = '0;
  logic        res_valid = 1'b0;
  logic        work;
  logic        out_in;
  logic        in_out;
  logic [31:0] memory_address_A;
  logic [31:0] memory_address_OUT;
  logic        arr_in_valid;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] perf_cycles;

  int   tests = 0;
  int   fails = 0;
  logic err_m = 1'b0;

  cl_systolic_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_base(a_base), .out_base(out_base), .num_rows(num_rows),
    .res_valid(res_valid), .work(work), .out_in(out_in), .in_out(in_out),
    .memory_address_A(memory_address_A),
    .memory_address_OUT(memory_address_OUT),
    .arr_in_valid(arr_in_valid), .busy(busy), .done(done), .err(err),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string tag, input logic [6:0] ab,
                         input logic [6:0] ob, input int n, input int lat,
                         input int nres, input int bstart);
    logic [31:0] ea[$];
    logic [31:0] eo[$];
    logic [31:0] oa[$];
    logic [31:0] oo[$];
    int exp_done, last, nw;
    int done_at = -1;
    int done_cnt = 0;
    int work_cnt = 0;
    int aiv_cnt = 0;
    logic exp_err;
    nw = (nres < n) ? nres : n;
    for (int i = 0; i < n; i++) ea.push_back(32'((int'(ab) + i) % 128));
    for (int i = 0; i < nw; i++) eo.push_back(32'((int'(ob) + i) % 128));
    if (n == 0) exp_done = 1;
    else if (nres >= n) exp_done = (n + 2 > n + lat + 1) ? n + 2 : n + lat + 1;
    else begin
      last = (nres > 0) ? nres + lat : 0;
      exp_done = ((n + 1 > last + 1) ? n + 1 : last + 1) + DRAIN_MAX;
    end
    exp_err = ((n > 0) && (nres != n)) || (bstart > 0);
    err_m = exp_err;
    @(posedge clk); #1;
    a_base = ab; out_base = ob; num_rows = 8'(n); start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      start = (c == bstart);
      res_valid = (n > 0) && (c - 1 - lat >= 0) && (c - 1 - lat < nres);
      @(negedge clk);
      if (out_in) oa.push_back(memory_address_A);
      if (in_out) oo.push_back(memory_address_OUT);
      if (work) work_cnt++;
      if (arr_in_valid) aiv_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && c >= done_at + 2) break;
    end
    start = 1'b0; res_valid = 1'b0;
    chk({tag, ".done_cycle"}, 32'(done_at), 32'(exp_done));
    chk({tag, ".done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, ".work_cycles"}, 32'(work_cnt), 32'((n == 0) ? 0 : exp_done - 1));
    chk({tag, ".arr_valid_cycles"}, 32'(aiv_cnt), 32'(n));
    chk({tag, ".reads"}, 32'(oa.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size(); i++)
      chk({tag, ".addrA"}, (i < oa.size()) ? oa[i] : 32'hxxxx_xxxx, ea[i]);
    chk({tag, ".writes"}, 32'(oo.size()), 32'(eo.size()));
    for (int i = 0; i < eo.size(); i++)
      chk({tag, ".addrOUT"}, (i < oo.size()) ? oo[i] : 32'hxxxx_xxxx, eo[i]);
    chk({tag, ".err"}, 32'(err), 32'(err_m));
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
`ifdef SCHED_PERF_EN
    chk({tag, ".perf"}, perf_cycles, 32'(exp_done));
`else
    chk({tag, ".perf"}, perf_cycles, 32'd0);
`endif
  endtask

  initial begin
    int dn;
    #1;
    chk("rst.work", 32'(work), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.addrA", memory_address_A, 32'd0);
    chk("rst.addrOUT", memory_address_OUT, 32'd0);
    chk("rst.perf", perf_cycles, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_job("t1", 7'd0, 7'd64, 8, 4, 8, 0);
    run_job("t2", 7'd126, 7'd3, 4, 2, 4, 0);
    run_job("t3", 7'd5, 7'd9, 0, 0, 0, 0);
    run_job("t4a", 7'd20, 7'd40, 3, 1, 2, 0);
    run_job("t4b", 7'd30, 7'd50, 3, 0, 4, 0);
    run_job("t5", 7'd7, 7'd70, 6, 2, 6, 3);

    // abort mid-fetch; a start in the same cycle must lose to abort
    @(posedge clk); #1;
    a_base = 7'd10; num_rows = 8'd8; start = 1'b1;
    err_m = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("abort.work_before", 32'(work), 32'd1);
    @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("abort.work", 32'(work), 32'd0);
    chk("abort.out_in", 32'(out_in), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.aiv_tail", 32'(arr_in_valid), 32'd1);
    chk("abort.err", 32'(err), 32'(err_m));
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) chk("abort.aiv_drop", 32'(arr_in_valid), 32'd0);
      if (done) dn++;
    end
    chk("abort.no_done", 32'(dn), 32'd0);

    // reset while draining
    @(posedge clk); #1;
    a_base = 7'd0; out_base = 7'd64; num_rows = 8'd8; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      res_valid = (c - 5 >= 0) && (c - 5 < 8);
    end
    rst_n = 1'b0;
    #1;
    chk("rstmid.work", 32'(work), 32'd0);
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.in_out", 32'(in_out), 32'd0);
    chk("rstmid.aiv", 32'(arr_in_valid), 32'd0);
    chk("rstmid.addrOUT", memory_address_OUT, 32'd0);
    @(negedge clk);
    res_valid = 1'b0;
    rst_n = 1'b1;
    err_m = 1'b0;

    run_job("t6", 7'd0, 7'd100, 8, 3, 8, 0);

    for (int k = 0; k < 6; k++) begin
      int rn, rl;
      rn = int'($urandom_range(1, 20));
      rl = int'($urandom_range(0, 6));
      run_job("rnd", 7'($urandom), 7'($urandom), rn, rl, rn, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
